// File: rtl/fp_cmp_arbiter.sv
// fp_cmp_arbiter
// Two requesters share one single-precision compare datapath (FLE/FLT/FEQ).
// A round-robin arbiter grants one request per cycle. The compare is
// evaluated combinationally in the grant cycle. The result is captured in a
// one-entry output register with valid/ready backpressure.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         request handshake for requester N (N = 0, 1)
//   reqN_op                  00 FLE, 01 FLT, 10 FEQ, 11 reserved (answers 0)
//   reqN_rs1/rs2             operands a/b (IEEE-754 single)
//   reqN_tag                 opaque tag echoed with the result
//   rsp_valid/ready          result handshake
//   rsp_id, rsp_tag          owner and tag of the held result
//   rsp_data                 32'd1 when the compare is true, else 32'd0
//   rsp_nv                   invalid-operation flag
//   pri                      round-robin priority pointer (debug)
module fp_cmp_arbiter #(
    parameter int TAG_W   = 4,
    parameter bit RST_PRI = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [31:0]      req0_rs1,
    input  logic [31:0]      req0_rs2,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [31:0]      req1_rs1,
    input  logic [31:0]      req1_rs2,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_data,
    output logic             rsp_nv,
    output logic             pri
);

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             rsp_res_q, rsp_res_d;
    logic             rsp_nv_q, rsp_nv_d;
    logic             pri_q, pri_d;

    logic             gnt0, gnt1, out_free, accept;
    logic [1:0]       sel_op;
    logic [31:0]      a, b;
    logic [TAG_W-1:0] sel_tag;

    logic a_nan, b_nan, any_nan, any_snan, both_zero, eq, lt;
    logic cmp_res, cmp_nv;

    // Arbitration: priority pointer only matters when both are valid.
    assign gnt0     = req0_valid && (!req1_valid || (pri_q == 1'b0));
    assign gnt1     = req1_valid && (!req0_valid || (pri_q == 1'b1));
    assign out_free = !rsp_valid_q || rsp_ready;

    assign req0_ready = gnt0 && out_free && !rst;
    assign req1_ready = gnt1 && out_free && !rst;
    assign accept     = req0_ready || req1_ready;

    // Operand mux follows the grant; gnt0/gnt1 are mutually exclusive.
    assign sel_op  = gnt1 ? req1_op  : req0_op;
    assign a       = gnt1 ? req1_rs1 : req0_rs1;
    assign b       = gnt1 ? req1_rs2 : req0_rs2;
    assign sel_tag = gnt1 ? req1_tag : req0_tag;

    assign a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign any_nan   = a_nan || b_nan;
    assign any_snan  = (a_nan && !a[22]) || (b_nan && !b[22]);
    assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    assign eq        = (a == b) || both_zero;

    // Sign-magnitude ordering; infinities fall out naturally from the
    // magnitude compare and denormals are compared as encoded.
    always_comb begin
        lt = 1'b0;
        if (a[31] != b[31]) begin
            lt = a[31] && !both_zero;
        end else if (!a[31]) begin
            lt = a[30:0] < b[30:0];
        end else begin
            lt = a[30:0] > b[30:0];
        end
    end

    always_comb begin
        cmp_res = 1'b0;
        cmp_nv  = 1'b0;
        case (sel_op)
            2'b00: begin
                cmp_res = (lt || eq) && !any_nan;
                cmp_nv  = any_nan;
            end
            2'b01: begin
                cmp_res = lt && !any_nan;
                cmp_nv  = any_nan;
            end
            2'b10: begin
                cmp_res = eq && !any_nan;
                cmp_nv  = any_snan;
            end
            default: begin
                cmp_res = 1'b0;
                cmp_nv  = 1'b0;
            end
        endcase
    end

    // A retire and a new accept in the same cycle overwrite the register
    // with no bubble; a plain retire keeps the data fields unchanged.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_res_d   = rsp_res_q;
        rsp_nv_d    = rsp_nv_q;
        pri_d       = pri_q;
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt1;
            rsp_tag_d   = sel_tag;
            rsp_res_d   = cmp_res;
            rsp_nv_d    = cmp_nv;
            pri_d       = !gnt1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_res_q   <= 1'b0;
            rsp_nv_q    <= 1'b0;
            pri_q       <= RST_PRI;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_res_q   <= rsp_res_d;
            rsp_nv_q    <= rsp_nv_d;
            pri_q       <= pri_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_data  = {31'd0, rsp_res_q};
    assign rsp_nv    = rsp_nv_q;
    assign pri       = pri_q;

endmodule

// File: doc/fp_cmp_arbiter.md
Name: fp_cmp_arbiter

Overview:
Shares one single-precision compare datapath (FLE/FLT/FEQ) between two requesters, e.g. two FP issue slots. A round-robin arbiter grants one request per cycle. The IEEE-754 compare is evaluated in the grant cycle, and the result is held in a one-entry output register with valid/ready backpressure. The block returns RISC-V style results (32'd1 = true, 32'd0 = false) and an invalid-operation (NV) flag to the FP writeback/fflags logic.

Parameters:
TAG_W, 4, width of the opaque tag carried from request to response.
RST_PRI, 0, requester that holds priority after reset (0 or 1).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has a valid operation.
req0_ready  out  1  requester 0's operation is accepted this cycle.
req0_op  in  2  00 FLE, 01 FLT, 10 FEQ, 11 reserved.
req0_rs1  in  32  operand a.
req0_rs2  in  32  operand b.
req0_tag  in  TAG_W  tag returned with the result.
req1_valid, req1_ready, req1_op, req1_rs1, req1_rs2, req1_tag: same as requester 0, for requester 1.
rsp_valid  out  1  result register holds a valid result.
rsp_ready  in  1  consumer takes the result this cycle.
rsp_id  out  1  requester that owns the result.
rsp_tag  out  TAG_W  tag of the result.
rsp_data  out  32  32'd1 if the compare is true, else 32'd0.
rsp_nv  out  1  invalid-operation flag.
pri  out  1  current round-robin priority pointer (debug).

Behaviour:
- Reset (synchronous, rst=1 at the clock edge): rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_data=0, rsp_nv=0, pri=RST_PRI. req_ready is low while rst=1.
- Reset mid-operation drops any held result; it is not replayed.
- out_free = !rsp_valid || rsp_ready. This path is combinational, so the block accepts back-to-back requests at 1 per cycle under continuous rsp_ready.
- Grant (combinational):
  - If both requesters are valid, grant requester `pri`.
  - If only one is valid, grant that one.
  - req_ready[i] = grant[i] && out_free && !rst. At most one req_ready is high per cycle.
  - A requester must hold valid and its payload stable until ready. The arbiter never grants without valid.
- Accept: when req_ready[i] && req_valid[i], on the next edge load the compare result, id=i and tag into the output register and set rsp_valid=1. Latency is 1 cycle from accept to rsp_valid.
- Priority update:
  - After an accepted grant to i, pri becomes !i.
  - With no accept, pri is unchanged. This includes the case where both requesters are valid but output is stalled.
- Output register:
  - rsp_valid && !rsp_ready: all rsp_* outputs hold stable and no accept occurs.
  - rsp_ready with no new accept: rsp_valid goes to 0 and the data fields keep their old values.
  - rsp_ready with a new accept in the same cycle: the register is overwritten, rsp_valid stays 1, and there is no bubble.
- Compare semantics (a=rs1, b=rs2):
  - NaN means exp==8'hFF and mant!=0.
  - sNaN means a NaN with mant[22]==0.
  - Zero means a[30:0]==0.
  - Equal: a==b bitwise, or both operands are zero (+0 == -0).
  - Less-than on non-NaN operands:
    - Signs differ: a<b iff a is negative and the operands are not both zero.
    - Both positive: a<b iff a[30:0] < b[30:0].
    - Both negative: a<b iff a[30:0] > b[30:0].
  - FEQ: data = equal && no NaN. nv = sNaN on either operand.
  - FLT: data = less-than && no NaN. nv = any NaN.
  - FLE: data = (less-than || equal) && no NaN. nv = any NaN.
  - op 11: data=0, nv=0. It is still accepted and answered, so the requester is never hung.
- Infinities compare as ordinary ordered values; no special-casing is needed beyond the NaN rules. Denormals are compared as encoded, with no flush.

Test Plan:
- Reset, then req0 FLT 0x3F800000,0x40000000 with rsp_ready=1 -> req0_ready=1 in cycle 0; in cycle 1 rsp_valid=1, rsp_data=1, rsp_nv=0, rsp_id=0, tag echoed; pri becomes 1.
- Both valid for 4 cycles with rsp_ready=1 -> grants alternate 0,1,0,1, giving 4 responses in consecutive cycles with ids 0,1,0,1.
- Signed and zero cases:
  - FLT 0xC0000000,0xBF800000 -> 1.
  - FLE 0x80000000,0x00000000 -> 1.
  - FLT 0x80000000,0x00000000 -> 0.
  - FEQ 0x80000000,0x00000000 -> 1.
- NaN handling:
  - FEQ 0x7FC00000,0x7FC00000 -> data=0, nv=0.
  - FEQ 0x7F800001,0x3F800000 -> data=0, nv=1.
  - FLT 0x7FC00000,0x3F800000 -> data=0, nv=1.
- Backpressure: hold rsp_ready=0 for 3 cycles with both requesters valid -> both req_ready stay low, rsp_* stays stable, pri is unchanged. Then rsp_ready=1 -> old result retires and a new one is loaded in the same cycle, with rsp_valid staying 1.
- Assert rst while rsp_valid=1 and requesters are valid -> next cycle rsp_valid=0, pri=RST_PRI, no req_ready during reset. Op 11 afterwards -> data=0, nv=0, answered in 1 cycle.
